// File: rtl/gf2mz_pkg.sv
// Shared constants, FSM state encoding and slot placement helper for the GF(2^m)[z] coefficient loader.
package gf2mz_pkg;

  localparam int unsigned N     = 149;
  localparam int unsigned M     = 83;
  localparam int unsigned D     = 5;
  localparam int unsigned WIDTH = M * D;
  localparam int unsigned DEPTH = (N / D) + (((N % D) != 0) ? 1 : 0);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = $clog2(N + 1);
  localparam int unsigned SW    = $clog2(D);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // LSB position of slot s; slot 0 occupies the most significant m bits.
  function automatic int unsigned slot_lsb(input int unsigned s);
    return WIDTH - (s + 1) * M;
  endfunction

endpackage

// File: rtl/gf2mz_word_packer.sv
// d-slot packing register: collects coefficients into one memory word, unfilled slots stay zero.
module gf2mz_word_packer
  import gf2mz_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [M-1:0]     i_data,
  output logic [WIDTH-1:0] o_word_c,
  output logic             o_full_c
);

  logic [M-1:0]  r_slot [D];
  logic [SW-1:0] r_idx;

  // Slot storage and slot counter; a clear wins over a load because the word is being emitted.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned s = 0; s < D; s++) r_slot[s] <= '0;
      r_idx <= '0;
    end else if (i_clr) begin
      for (int unsigned s = 0; s < D; s++) r_slot[s] <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      for (int unsigned s = 0; s < D; s++) begin
        if (r_idx == SW'(s)) r_slot[s] <= i_data;
      end
      r_idx <= r_idx + SW'(1);
    end
  end

  // Packed word including the coefficient being accepted this cycle, so it can be written without a stall.
  always_comb begin
    o_word_c = '0;
    for (int unsigned s = 0; s < D; s++) begin
      o_word_c[slot_lsb(s) +: M] = (i_load && (r_idx == SW'(s))) ? i_data : r_slot[s];
    end
  end

  assign o_full_c = (r_idx == SW'(D - 1));

endmodule

// File: rtl/gf2mz_coef_loader.sv
// Streaming loader packing GF(2^m) coefficients into d-element RAM words for the GF(2^m)[z] multiplier.
// Optional macro GF2MZ_LOAD_CLEAR_EN: zero-fill words beyond ceil(len/d) after the load.
module gf2mz_coef_loader
  import gf2mz_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [LW-1:0]    len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_data,
  output logic [WIDTH-1:0] mem_do,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_cnt;
  logic [AW-1:0]    r_word_addr;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_mem_do;
  logic [AW-1:0]    r_mem_addr;
  logic             r_mem_we;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_start_ok;
  logic             w_err_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_emit;
  logic             w_clr_we;
  logic [WIDTH-1:0] w_word_c;
  logic             w_full_c;

  gf2mz_word_packer u_packer (
    .clk      (clk),
    .rst_b    (rst_b),
    .i_load   (w_accept),
    .i_clr    (w_start_ok | w_emit),
    .i_data   (in_data),
    .o_word_c (w_word_c),
    .o_full_c (w_full_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, handshake and write-trigger decode.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_err_nxt   = 1'b0;
    w_clr_we    = 1'b0;
    w_accept    = r_in_ready & in_valid;
    w_last      = w_accept && (r_cnt == (r_len - LW'(1)));
    w_emit      = w_accept && (w_full_c || w_last);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if ((len == '0) || (len > LW'(N))) begin
            w_err_nxt = 1'b1;
          end else begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (w_last) begin
`ifdef GF2MZ_LOAD_CLEAR_EN
          if (r_word_addr == AW'(DEPTH - 1)) w_state_nxt = ST_DONE;
          else                               w_state_nxt = ST_CLEAR;
`else
          w_state_nxt = ST_DONE;
`endif
        end
      end
`ifdef GF2MZ_LOAD_CLEAR_EN
      ST_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_word_addr == AW'(DEPTH - 1)) w_state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered status outputs and load bookkeeping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
    end else begin
      r_in_ready <= (w_state_nxt == ST_FILL);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (r_state == ST_DONE);
      r_err      <= w_err_nxt;
      if (w_start_ok) begin
        r_len <= len;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + LW'(1);
      end
    end
  end

  // RAM write port: packed words during fill, zero words during clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_mem_do    <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_word_addr <= '0;
    end else begin
      r_mem_we <= w_emit | w_clr_we;
      if (w_start_ok) begin
        r_word_addr <= '0;
      end else if (w_emit) begin
        r_mem_do    <= w_word_c;
        r_mem_addr  <= r_word_addr;
        r_word_addr <= r_word_addr + AW'(1);
      end else if (w_clr_we) begin
        r_mem_do    <= '0;
        r_mem_addr  <= r_word_addr;
        r_word_addr <= r_word_addr + AW'(1);
      end
    end
  end

  assign in_ready = r_in_ready;
  assign mem_do   = r_mem_do;
  assign mem_addr = r_mem_addr;
  assign mem_we   = r_mem_we;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_gf2mz_coef_loader.sv
// Scoreboard bench for gf2mz_coef_loader: driver queues expected RAM writes, a negedge monitor checks them.
module tb_gf2mz_coef_loader;

  localparam int TM     = 83;
  localparam int TWIDTH = 415;
  localparam int TAW    = 5;
  localparam int TLW    = 8;
  localparam int TDEPTH = 30;
`ifdef GF2MZ_LOAD_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              start = 1'b0;
  logic [TLW-1:0]    len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [TM-1:0]     in_data = '0;
  logic [TWIDTH-1:0] mem_do;
  logic [TAW-1:0]    mem_addr;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct {
    logic [TAW-1:0]    addr;
    logic [TWIDTH-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;

  gf2mz_coef_loader dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .mem_do   (mem_do),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [TWIDTH-1:0] act, input logic [TWIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [TM-1:0] coef(input int k, input bit hi);
    logic [TM-1:0] c;
    c = TM'(k);
    if (hi) c = c | (TM'(k) << 76);
    return c;
  endfunction

  // Expected word: coefficients first_k..first_k+4, slot 0 in the top bits, beyond ln zero.
  function automatic logic [TWIDTH-1:0] exp_word(input int first_k, input int ln, input bit hi);
    logic [TWIDTH-1:0] w;
    logic [TM-1:0]     v;
    w = '0;
    for (int s = 0; s < 5; s++) begin
      v = ((first_k + s) <= ln) ? coef(first_k + s, hi) : '0;
      w = (w << TM) | TWIDTH'(v);
    end
    return w;
  endfunction

  // Monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", TWIDTH'(mem_addr), '1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", TWIDTH'(mem_addr), TWIDTH'(e.addr));
        chk("wr_data", mem_do, e.data);
      end
    end
  end

  task automatic run_load(input int ln, input bit gap, input bit hi, input int restart_at);
    int  i;
    int  n;
    int  guard;
    int  words;
    int  clr_k;
    bit  rdy;
    wr_t e;
    words = (ln + 4) / 5;
    clr_k = CLR_EN ? (TDEPTH - words) : 0;
    for (int w = 0; w < words; w++) begin
      e.addr = TAW'(w);
      e.data = exp_word(w * 5 + 1, ln, hi);
      sb.push_back(e);
    end
    for (int w = words; w < words + clr_k; w++) begin
      e.addr = TAW'(w);
      e.data = '0;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    len   = TLW'(ln);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", TWIDTH'(busy), TWIDTH'(1));
    chk("ready_after_start", TWIDTH'(in_ready), TWIDTH'(1));
    i = 0;
    guard = 0;
    while (i < ln && guard < 1000) begin
      in_valid = 1'b1;
      in_data  = coef(i + 1, hi);
      if (i == restart_at) begin
        start = 1'b1;
        len   = TLW'(3);
      end
      rdy = in_ready;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      guard++;
      if (rdy) begin
        i++;
        if (gap && i < ln) @(negedge clk);
      end
    end
    if (i < ln) chk("accept_timeout", TWIDTH'(i), TWIDTH'(ln));
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", TWIDTH'(n), TWIDTH'(2 + clr_k));
    chk("busy_at_done", TWIDTH'(busy), TWIDTH'(0));
    @(negedge clk);
    chk("done_one_cycle", TWIDTH'(done), TWIDTH'(0));
    chk("sb_drained", TWIDTH'(sb.size()), TWIDTH'(0));
  endtask

  task automatic bad_len(input int ln);
    @(negedge clk);
    start = 1'b1;
    len   = TLW'(ln);
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", TWIDTH'(err), TWIDTH'(1));
    chk("err_busy", TWIDTH'(busy), TWIDTH'(0));
    chk("err_we", TWIDTH'(mem_we), TWIDTH'(0));
    @(negedge clk);
    chk("err_one_cycle", TWIDTH'(err), TWIDTH'(0));
    chk("err_ready", TWIDTH'(in_ready), TWIDTH'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", TWIDTH'(in_ready), '0);
    chk("rst_we", TWIDTH'(mem_we), '0);
    chk("rst_busy", TWIDTH'(busy), '0);
    chk("rst_done", TWIDTH'(done), '0);
    chk("rst_err", TWIDTH'(err), '0);
    chk("rst_do", mem_do, '0);
    chk("rst_addr", TWIDTH'(mem_addr), '0);

    run_load(149, 1'b0, 1'b0, -1);
    run_load(7, 1'b0, 1'b0, -1);
    run_load(10, 1'b1, 1'b0, -1);
    bad_len(0);
    bad_len(150);

    // Abort after three of five coefficients: nothing may be written.
    @(negedge clk);
    start = 1'b1;
    len   = TLW'(5);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data  = coef(90 + j, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("abort_ready", TWIDTH'(in_ready), '0);
    chk("abort_we", TWIDTH'(mem_we), '0);
    chk("abort_busy", TWIDTH'(busy), '0);
    chk("abort_do", mem_do, '0);
    chk("abort_addr", TWIDTH'(mem_addr), '0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    run_load(5, 1'b0, 1'b1, -1);
    run_load(10, 1'b0, 1'b0, 3);

    repeat (3) @(negedge clk);
    chk("final_sb_empty", TWIDTH'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf2mz_coef_loader.md
# gf2mz_coef_loader

Streaming loader that packs GF(2^m) coefficients of a polynomial in GF(2^m)[z] into the d-element memory words consumed by the GF(2^m)[z] multiplier (memories A and B). It accepts one m-bit coefficient per cycle over a valid/ready handshake and writes full or zero-padded words to a single-port RAM. It sits directly upstream of the multiplier top; its `done` gates the multiplier `start`.

## Interface
- `n`, 149: maximum polynomial length in coefficients
- `m`, 83: GF(2^m) element width
- `d`, 5: coefficients per memory word
- `WIDTH`, m*d: memory word width
- `DEPTH`, (n/d)+((n%d)!=0): words per polynomial
- `AW`, `CLOG2(DEPTH): address width
- `LW`, `CLOG2(n+1): length field width

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst_b`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begin a load, samples `len`
- `len`  in  LW  coefficient count, legal 1..n
- `in_valid`  in  1  `in_data` holds a coefficient
- `in_ready`  out  1  loader accepts coefficient this cycle
- `in_data`  in  m  coefficient, index order 0,1,2,...
- `mem_do`  out  WIDTH  packed word to RAM data-in
- `mem_addr`  out  AW  RAM word address
- `mem_we`  out  1  RAM write enable
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse, load complete
- `err`  out  1  one-cycle pulse, illegal `len`

## Operation
- Coefficient i → address i/d, slot i%d; slot 0 at bits [WIDTH-1:WIDTH-m], slot s at [WIDTH-1-s*m : WIDTH-(s+1)*m].
- FSM: IDLE → FILL → (CLEAR) → DONE → IDLE.
- IDLE: `start` with 1≤len≤n → FILL, clear slot/word counters and packer. `start` with len=0 or len>n → `err` pulse next cycle, no writes, stay IDLE. `start` outside IDLE ignored.
- FILL: `in_ready`=1. Transfer when `in_valid`&`in_ready`. Accepted coefficient placed in current slot; when slot d-1 or coefficient len-1 accepted, the packed word (unfilled slots zero) is registered to `mem_do`/`mem_addr` with `mem_we`=1 next cycle; packer clears, address increments. After coefficient len-1: `in_ready` drops next cycle, → CLEAR if enabled, else DONE.
- CLEAR (macro only): writes all-zero words at addresses ceil(len/d)..DEPTH-1, one per cycle; skipped when ceil(len/d)=DEPTH.
- DONE: `done`=1 one cycle, → IDLE.
- `mem_we` is never asserted outside FILL-triggered writes and CLEAR.

## Timing
- Reset: `in_ready`, `mem_we`, `busy`, `done`, `err` = 0; `mem_do`, `mem_addr` = 0; FSM IDLE. All outputs registered.
- `start` at cycle 0 → `busy`=1, `in_ready`=1 from cycle 1.
- Throughput one coefficient per cycle; word write overlaps next acceptances (no stall).
- Last coefficient accepted cycle t → final write at t+1 → `done` at t+2 (no clear) or at t+2+K (K clear words); `busy` falls with `done`.
- `in_valid` low: no acceptance, no state change; gaps arbitrary.
- Reset mid-load: immediate abort; partially packed word discarded, no write.

## Configuration
- `GF2MZ_LOAD_CLEAR_EN` defined: CLEAR state compiled in; words beyond ceil(len/d) zeroed so short polynomials leave no stale data for the multiplier.
- Undefined: no CLEAR state; words beyond ceil(len/d) untouched; `done` at t+2 always.

## Structure
- Shared package `gf2mz_pkg`: FSM state enum, default n/m/d constants, slot bit-offset function.
- Sub-module `gf2mz_word_packer`: d-slot register, slot counter, load/clear controls, emits packed word and "full" flag.

## Test plan
- len=149, data=i+1, in_valid constant → 30 writes at addr 0..29, addr 29 slots 0..3 = 146..149, slot 4 = 0, `done` 2 cycles after last accept.
- len=7 with `GF2MZ_LOAD_CLEAR_EN` → addr 0 = {1..5}, addr 1 = {6,7,0,0,0}, addr 2..29 written 0, `done` 30 cycles after last accept; without macro addr 2..29 untouched, `done` at t+2.
- len=10, `in_valid` alternating 1/0 → exactly 2 writes, words {1..5},{6..10}, no dropped/duplicated coefficient.
- len=0 and len=150 → `err` pulse one cycle, `busy`/`mem_we` stay 0.
- `rst_b` low after 3 of 5 coefficients → no write, outputs 0; fresh load afterwards correct.
- `start` pulsed during FILL → ignored, load completes unchanged.
